// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction memory.
//   NOP_INSTR : word returned for faulted fetches (addi x0,x0,0)
//   fault_e   : response fault code
//   rsp_t     : response record at the default 32-bit widths
//   sat_inc32 : saturating 32-bit increment used by the fetch counter
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] addr;
    fault_e      fault;
  } rsp_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_if.sv
// imem_if: program-load, fetch-request and fetch-response signals of the
// instruction memory.
//   master : drives load_*, req_valid, req_addr, flush
//   slave  : drives req_ready, rsp_*, fetch_cnt (the memory itself)
interface imem_if
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              load_en;
  logic [IDX_W-1:0]  load_addr;
  logic [DATA_W-1:0] load_data;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  fault_e            rsp_fault;
  logic [31:0]       fetch_cnt;

  modport master (
    output load_en, load_addr, load_data, req_valid, req_addr, flush,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, fetch_cnt
  );

  modport slave (
    input  load_en, load_addr, load_data, req_valid, req_addr, flush,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, fetch_cnt
  );
endinterface

// File: rtl/imem_rsp_pipe.sv
// imem_rsp_pipe: response delay line behind the read stage.
//   clk, rst_n : clock, asynchronous active-low reset (clears all stages)
//   flush_i    : clears the valid bit of every stage at the edge
//   valid_i/data_i : response entering the line
//   valid_o/data_o : response leaving the line after STAGES cycles
// STAGES=0 degenerates to a wire.
module imem_rsp_pipe #(
  parameter int STAGES = 0,
  parameter int PAY_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [PAY_W-1:0] data_i,
  output logic             valid_o,
  output logic [PAY_W-1:0] data_o
);
  genvar gi;
  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, flush_i};
      assign valid_o     = valid_i;
      assign data_o      = data_i;
    end else begin : g_delay
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             valid_q, valid_d;
        logic [PAY_W-1:0] data_q, data_d;
        // Whatever is entering a stage at a flush edge was accepted before
        // the flush, so it is killed along with everything already inside.
        if (gi == 0) begin : g_src
          assign valid_d = valid_i & ~flush_i;
          assign data_d  = data_i;
        end else begin : g_src
          assign valid_d = g_stage[gi-1].valid_q & ~flush_i;
          assign data_d  = g_stage[gi-1].data_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
          end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
          end
        end
      end
      assign valid_o = g_stage[STAGES-1].valid_q;
      assign data_o  = g_stage[STAGES-1].data_q;
    end
  endgenerate
endmodule

// File: rtl/imem_pipelined.sv
// imem_pipelined: word-addressed instruction store with a program-load
// port and a pipelined fetch port.
//   clk, rst_n : clock, asynchronous active-low reset (array not cleared)
//   bus        : imem_if slave -- load_*, req_*, flush, rsp_*, fetch_cnt
// Loads take priority over fetches. Faulted fetches return NOP with a
// fault code. Responses appear LATENCY cycles after acceptance.
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam int                PAY_W   = DATA_W + ADDR_W + 2;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic              accept_d;
  logic [IDX_W-1:0]  word_idx_d;
  fault_e            fault_d;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  fault_e            s1_fault_q;
  logic [DATA_W-1:0] s1_instr_d;

  logic              out_valid_d;
  logic [PAY_W-1:0]  out_pay_d;
  logic [DATA_W-1:0] out_instr_d;
  logic [ADDR_W-1:0] out_addr_d;
  fault_e            out_fault_d;
  logic [31:0]       fetch_cnt_q;

  assign bus.req_ready = !bus.load_en;
  assign accept_d      = bus.req_valid && !bus.load_en;
  assign word_idx_d    = bus.req_addr[IDX_W+1:2];

  // Misalignment is checked first so it wins when both faults apply.
  always_comb begin
    fault_d = FAULT_NONE;
    if (bus.req_addr[1:0] != 2'b00) begin
      fault_d = FAULT_MISALIGN;
    end else if ({2'b00, bus.req_addr[ADDR_W-1:2]} >= DEPTH_A) begin
      fault_d = FAULT_RANGE;
    end
  end

  // Array plus registered read, kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      mem[bus.load_addr] <= bus.load_data;
    end
    if (accept_d) begin
      rd_data_q <= mem[word_idx_d];
    end
  end

  // Read stage control. A request accepted on a flush edge is the redirect
  // target, so flush does not touch this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_fault_q <= FAULT_NONE;
    end else begin
      s1_valid_q <= accept_d;
      if (accept_d) begin
        s1_addr_q  <= bus.req_addr;
        s1_fault_q <= fault_d;
      end
    end
  end

  assign s1_instr_d = (s1_fault_q == FAULT_NONE) ? rd_data_q : DATA_W'(NOP_INSTR);

  imem_rsp_pipe #(
    .STAGES (LATENCY - 1),
    .PAY_W  (PAY_W)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.flush),
    .valid_i (s1_valid_q),
    .data_i  ({s1_instr_d, s1_addr_q, s1_fault_q}),
    .valid_o (out_valid_d),
    .data_o  (out_pay_d)
  );

  assign out_instr_d = out_pay_d[PAY_W-1 -: DATA_W];
  assign out_addr_d  = out_pay_d[ADDR_W+1 -: ADDR_W];
  assign out_fault_d = fault_e'(out_pay_d[1:0]);

  // Payload is qualified by valid: the raw read register is not reset, and
  // the outputs must read zero while idle after reset.
  assign bus.rsp_valid = out_valid_d;
  assign bus.rsp_instr = out_valid_d ? out_instr_d : '0;
  assign bus.rsp_addr  = out_valid_d ? out_addr_d : '0;
  assign bus.rsp_fault = out_valid_d ? out_fault_d : FAULT_NONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else if (out_valid_d && out_fault_d == FAULT_NONE) begin
      fetch_cnt_q <= sat_inc32(fetch_cnt_q);
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_imem_pipelined.sv
// Scoreboard bench: one DUT at LATENCY=1 and one at LATENCY=3 share the
// same stimulus. Accepted requests push an expected response (with its due
// time) into a per-DUT queue; a negedge monitor pops and compares.
module tb_imem_pipelined;
  import imem_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    time         t;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t actual=%h required=%h", nm, $time, act, req);
    end
  endfunction

  // Reference memory: a load written at an edge is visible to fetches at
  // later edges. Loads and accepted fetches never share an edge.
  always @(posedge clk) begin
    if (load_en) mem_m[load_addr] = load_data;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;

    imem_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

    assign bus.load_en   = load_en;
    assign bus.load_addr = load_addr;
    assign bus.load_data = load_data;
    assign bus.req_valid = req_valid;
    assign bus.req_addr  = req_addr;
    assign bus.flush     = flush;

    imem_pipelined #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    exp_t        q[$];
    exp_t        e_new;
    exp_t        e_got;
    logic [31:0] cnt_m = '0;

    // Reference model: acceptance, fault rules, flush drops older requests.
    always @(posedge clk) begin
      if (rst_n) begin
        if (flush) q.delete();
        if (req_valid && !load_en) begin
          e_new.t    = $time + (LAT - 1) * 10 + 5;
          e_new.addr = req_addr;
          if (req_addr % 4 != 0)          e_new.fault = 2'b01;
          else if (req_addr / 4 >= DEPTH) e_new.fault = 2'b10;
          else                            e_new.fault = 2'b00;
          e_new.instr = (e_new.fault != 2'b00) ? NOP : mem_m[req_addr / 4];
          q.push_back(e_new);
        end
      end
    end

    always @(negedge rst_n) begin
      q.delete();
      cnt_m = '0;
      #1;
      chk($sformatf("L%0d rst_valid", LAT), bus.rsp_valid, 0);
      chk($sformatf("L%0d rst_instr", LAT), bus.rsp_instr, 0);
      chk($sformatf("L%0d rst_addr", LAT), bus.rsp_addr, 0);
      chk($sformatf("L%0d rst_fault", LAT), bus.rsp_fault, 0);
      chk($sformatf("L%0d rst_cnt", LAT), bus.fetch_cnt, 0);
    end

    always @(negedge clk) begin
      chk($sformatf("L%0d req_ready", LAT), bus.req_ready, !load_en);
      chk($sformatf("L%0d fetch_cnt", LAT), bus.fetch_cnt, cnt_m);
      if (q.size() > 0 && q[0].t == $time) begin
        e_got = q.pop_front();
        chk($sformatf("L%0d rsp_valid", LAT), bus.rsp_valid, 1);
        chk($sformatf("L%0d rsp_instr a=%h", LAT, e_got.addr), bus.rsp_instr, e_got.instr);
        chk($sformatf("L%0d rsp_addr", LAT), bus.rsp_addr, e_got.addr);
        chk($sformatf("L%0d rsp_fault a=%h", LAT, e_got.addr), bus.rsp_fault, e_got.fault);
        $display("L%0d rsp @%0t addr=%h instr=%h fault=%0d", LAT, $time,
                 bus.rsp_addr, bus.rsp_instr, bus.rsp_fault);
        if (e_got.fault == 2'b00 && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
      end else begin
        chk($sformatf("L%0d idle_valid", LAT), bus.rsp_valid, 0);
      end
    end
  end

  // One bus cycle: drive just after an edge, hold through the next edge.
  task automatic step(input logic ld, input logic [7:0] la, input logic [31:0] ldd,
                      input logic rv, input logic [31:0] ra, input logic fl);
    load_en   = ld;
    load_addr = la;
    load_data = ldd;
    req_valid = rv;
    req_addr  = ra;
    flush     = fl;
    if (rv || fl) $display("tx @%0t req=%0d addr=%h load=%0d flush=%0d", $time, rv, ra, ld, fl);
    @(posedge clk);
    #1;
    load_en   = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic fl);
    step(0, 0, 0, 1, a, fl);
  endtask

  initial begin
    logic        r_ld, r_rv, r_fl;
    logic [31:0] r_addr;
    int          sel;

    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Program load: random background, then the known words.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), $urandom, 0, 0, 0);
    step(1, 8'd0, 32'h0000_0013, 0, 0, 0);
    step(1, 8'd1, 32'h0020_8133, 0, 0, 0);
    step(1, 8'd2, 32'h0031_01B3, 0, 0, 0);

    // Basic back-to-back fetches.
    fetch(32'h0, 0);
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    idle(5);

    // Faults, including misaligned winning over out-of-range.
    fetch(32'h6, 0);
    fetch(32'h400, 0);
    fetch(32'h402, 0);
    fetch(32'hFFFF_FFFC, 0);
    idle(5);

    // Load/fetch collision, then fetch of the freshly loaded word.
    step(1, 8'd1, 32'hDEAD_BEEF, 1, 32'h4, 0);
    fetch(32'h4, 0);
    idle(5);

    // Flush with older requests in flight.
    step(1, 8'd1, 32'h0020_8133, 0, 0, 0);
    fetch(32'h0, 0);
    fetch(32'h4, 0);
    fetch(32'h8, 1);
    idle(6);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r_ld = ($urandom % 8) == 0;
      r_rv = ($urandom % 4) != 0;
      r_fl = ($urandom % 16) == 0;
      sel  = int'($urandom % 8);
      if (sel <= 4)      r_addr = ($urandom % DEPTH) * 4;
      else if (sel == 5) r_addr = ($urandom % DEPTH) * 4 + 1 + ($urandom % 3);
      else if (sel == 6) r_addr = (DEPTH + ($urandom % 1000)) * 4;
      else               r_addr = $urandom;
      step(r_ld, 8'($urandom), $urandom, r_rv, r_addr, r_fl);
    end
    idle(4);

    // Reset with two requests in flight; memory must survive.
    step(1, 8'd1, 32'h0020_8133, 0, 0, 0);
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    #1 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    fetch(32'h4, 0);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
